async_fifo_rd_ctrl: RTL and testbench
=====================================

Name: async_fifo_rd_ctrl

Overview:
- Read-domain controller of the async FIFO. It owns the binary and Gray read pointers and brings the write-domain Gray pointer into rclk through a 2-flop synchronizer.
- It generates the registered empty, almost_empty, fill-count and underflow flags, and drives the read address into the dual-port FIFO memory.
- It is the read-side counterpart of the write-pointer/full logic that the driver and monitor exercise.

Parameters:
- ADDR_WIDTH, 4, log2 of FIFO depth (depth 16).
- ALMOST_EMPTY_TH, 2, almost_empty asserts when rd_count <= this value.

Ports:
- rclk  in  1  read-domain clock
- rrst_n  in  1  asynchronous active-low reset
- r_en  in  1  read request from the consumer
- wptr_gray  in  ADDR_WIDTH+1  write-domain Gray pointer, asynchronous to rclk
- raddr  out  ADDR_WIDTH  memory read address, equal to rbin[ADDR_WIDTH-1:0]
- rptr_gray  out  ADDR_WIDTH+1  registered Gray read pointer, sent to the write domain
- empty  out  1  FIFO empty (registered)
- almost_empty  out  1  rd_count <= ALMOST_EMPTY_TH (registered)
- rd_count  out  ADDR_WIDTH+1  entries available, as seen from rclk
- underflow  out  1  one-cycle pulse when a read is attempted while empty

Behaviour:
- Reset:
  - Asserting rrst_n low asynchronously clears rbin, rptr_gray, both synchronizer stages, rd_count and underflow to 0, and sets empty=1 and almost_empty=1.
  - Deassertion takes effect at the next rclk edge.
  - Reset mid-operation discards all read progress and leaves empty=1, regardless of wptr_gray.
- Read acceptance:
  - rd_ok = r_en & ~empty.
  - rbin_next = rbin + rd_ok, modulo 2^(ADDR_WIDTH+1); rgray_next = (rbin_next >> 1) ^ rbin_next.
  - rbin and rptr_gray register rbin_next and rgray_next on each rclk edge.
- Read address: raddr is taken from the current rbin, so memory data at raddr is the head entry. After an accepted read, raddr advances on the next edge.
- Synchronizer: wq1 <= wptr_gray; wq2 <= wq1. No logic is allowed between the two stages. The synchronized pointer is converted with wbin_s = gray2bin(wq2).
- Empty: empty <= (rgray_next == wq2).
  - A read that consumes the last entry raises empty on the same edge that advances rbin, so there is no extra read.
  - A new write becomes visible no earlier than 3 rclk edges after wptr_gray changes: 2 synchronizer edges plus 1 for the empty register.
- Count: rd_count <= wbin_s - rbin_next, as a (ADDR_WIDTH+1)-bit unsigned subtraction, so pointer wrap-around is handled naturally. The value lies in the range 0..2^ADDR_WIDTH.
- almost_empty: almost_empty <= (wbin_s - rbin_next) <= ALMOST_EMPTY_TH.
- Underflow:
  - underflow <= r_en & empty; it is high for one cycle per offending cycle.
  - On underflow the pointers do not move and the memory is not read.
- Simultaneous events: an accepted read in the same cycle that the synchronized write pointer advances gives the net count wbin_s - rbin_next. Empty is never asserted spuriously in that case.
- Pointer wrap: rbin rolls over from 2^(ADDR_WIDTH+1)-1 to 0. rptr_gray must change by exactly one bit per increment, including at wrap.
- Pessimism: empty and rd_count may lag writes by the synchronizer delay. They must never over-report available data.

Decomposition:
- Package async_fifo_rtl_pkg holds:
  - the ADDR_WIDTH default;
  - the typedef ptr_t, logic [ADDR_WIDTH:0];
  - the functions bin2gray and gray2bin.
- Sub-module sync_2ff, parameterised by width, on rclk/rrst_n, implements the wq1/wq2 stages. It is shared with the write-side controller.

Test Plan:
- Reset: hold rrst_n=0 while wptr_gray=5'b00110 -> empty=1, almost_empty=1, rd_count=0, rptr_gray=0, underflow=0. After release, empty stays 1 for 2 edges and then reads 0 on the 3rd edge.
- Single write latency: wptr_gray steps 0 to 1 at cycle 0 -> empty falls at edge 3 and rd_count=1. Then r_en=1 for one cycle -> raddr moves 0 to 1, rptr_gray=5'b00001, empty=1 on the same edge.
- Full drain: write 16 entries (wptr_gray=gray(16)=5'b11000) -> rd_count=16. Then r_en=1 for 16 cycles -> rd_count decrements 16..0, almost_empty rises when rd_count=2, empty=1 after the 16th read, raddr sequence 0..15.
- Underflow: with empty=1, r_en=1 for 3 cycles -> underflow high for 3 cycles, rbin stays constant, rptr_gray unchanged.
- Wrap-around: preset via 31 read/write pairs, then one more -> rbin goes 31 to 0 and rptr_gray goes 5'b10000 to 5'b00000 (single-bit change). The checker verifies every rptr_gray transition changes exactly one bit.
- Mid-operation reset: with rd_count=8 and r_en=1, pulse rrst_n=0 for 1 ns between edges -> all outputs return to reset values immediately with no rclk edge required, and no underflow pulse appears.

Source files
------------

// File: rtl/async_fifo_rtl_pkg.sv
// Shared types and pointer-code helpers for the async FIFO read and write controllers.
package async_fifo_rtl_pkg;

    localparam int unsigned DefaultAddrWidth = 4;

    typedef logic [DefaultAddrWidth:0] ptr_t;

    // Helpers work on a 32-bit container; callers zero-extend and truncate to their pointer width.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin = gray;
        for (int i = 1; i < 32; i++) begin
            bin = bin ^ (gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into the local clock domain.
module sync_2ff #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] q1_q, q2_q;

    // Plain flop-to-flop path: no logic may sit between the stages.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q1_q <= '0;
            q2_q <= '0;
        end else begin
            q1_q <= d_i;
            q2_q <= q1_q;
        end
    end

    assign q_o = q2_q;

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// Read-domain controller of the async FIFO: read pointers, synchronized write pointer,
// and registered empty / almost_empty / count / underflow flags.
module async_fifo_rd_ctrl
    import async_fifo_rtl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = DefaultAddrWidth,
    parameter int unsigned ALMOST_EMPTY_TH = 2
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  r_en,
    input  logic [ADDR_WIDTH:0]   wptr_gray,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic [ADDR_WIDTH:0]   rptr_gray,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   rd_count,
    output logic                  underflow
);

    localparam int unsigned PtrW = ADDR_WIDTH + 1;

    logic [PtrW-1:0] rbin_q, rbin_d;
    logic [PtrW-1:0] rgray_q, rgray_d;
    logic [PtrW-1:0] count_q, count_d;
    logic [PtrW-1:0] wq2, wbin_s;
    logic            empty_q, empty_d;
    logic            almost_empty_q, almost_empty_d;
    logic            underflow_q, underflow_d;
    logic            rd_ok;

    sync_2ff #(
        .Width(PtrW)
    ) u_wptr_sync (
        .clk_i (rclk),
        .rst_ni(rrst_n),
        .d_i   (wptr_gray),
        .q_o   (wq2)
    );

    always_comb begin
        rd_ok          = r_en & ~empty_q;
        rbin_d         = rbin_q + PtrW'(rd_ok);
        rgray_d        = PtrW'(bin2gray(32'(rbin_d)));
        wbin_s         = PtrW'(gray2bin(32'(wq2)));
        // Modular subtraction absorbs pointer wrap; range is 0..2^ADDR_WIDTH.
        count_d        = wbin_s - rbin_d;
        // Compare against the post-read pointer so the last read raises empty on its own edge.
        empty_d        = (rgray_d == wq2);
        almost_empty_d = (count_d <= PtrW'(ALMOST_EMPTY_TH));
        underflow_d    = r_en & empty_q;
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q         <= '0;
            rgray_q        <= '0;
            count_q        <= '0;
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
            underflow_q    <= 1'b0;
        end else begin
            rbin_q         <= rbin_d;
            rgray_q        <= rgray_d;
            count_q        <= count_d;
            empty_q        <= empty_d;
            almost_empty_q <= almost_empty_d;
            underflow_q    <= underflow_d;
        end
    end

    assign raddr        = rbin_q[ADDR_WIDTH-1:0];
    assign rptr_gray    = rgray_q;
    assign empty        = empty_q;
    assign almost_empty = almost_empty_q;
    assign rd_count     = count_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Directed, table-driven bench for the async FIFO read-domain controller.
module tb_async_fifo_rd_ctrl;

    logic       rclk;
    logic       rrst_n;
    logic       r_en;
    logic [4:0] wptr_gray;
    logic [3:0] raddr;
    logic [4:0] rptr_gray;
    logic       empty;
    logic       almost_empty;
    logic [4:0] rd_count;
    logic       underflow;

    int n_chk  = 0;
    int n_fail = 0;

    async_fifo_rd_ctrl #(
        .ADDR_WIDTH     (4),
        .ALMOST_EMPTY_TH(2)
    ) dut (
        .rclk        (rclk),
        .rrst_n      (rrst_n),
        .r_en        (r_en),
        .wptr_gray   (wptr_gray),
        .raddr       (raddr),
        .rptr_gray   (rptr_gray),
        .empty       (empty),
        .almost_empty(almost_empty),
        .rd_count    (rd_count),
        .underflow   (underflow)
    );

    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    typedef struct {
        string      name;
        logic       r_en;
        logic [4:0] wg;
        logic [3:0] raddr;
        logic [4:0] rg;
        logic       empty;
        logic       ae;
        logic [4:0] cnt;
        logic       uf;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_all(input string nm, input logic [3:0] e_raddr, input logic [4:0] e_rg,
                             input logic e_empty, input logic e_ae, input logic [4:0] e_cnt,
                             input logic e_uf);
        chk({nm, ".raddr"}, 32'(raddr), 32'(e_raddr));
        chk({nm, ".rptr_gray"}, 32'(rptr_gray), 32'(e_rg));
        chk({nm, ".empty"}, 32'(empty), 32'(e_empty));
        chk({nm, ".almost_empty"}, 32'(almost_empty), 32'(e_ae));
        chk({nm, ".rd_count"}, 32'(rd_count), 32'(e_cnt));
        chk({nm, ".underflow"}, 32'(underflow), 32'(e_uf));
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    // Every rptr_gray change outside reset must flip exactly one bit.
    logic [4:0] prev_rg;
    logic       prev_valid = 1'b0;

    always @(negedge rrst_n) prev_valid = 1'b0;

    always @(negedge rclk) begin
        if (prev_valid && rrst_n && (rptr_gray != prev_rg)) begin
            n_chk++;
            if ($countones(rptr_gray ^ prev_rg) != 1) begin
                n_fail++;
                $display("FAIL gray_step: %b -> %b, expected a single-bit change", prev_rg,
                         rptr_gray);
            end
        end
        prev_rg    = rptr_gray;
        prev_valid = rrst_n;
    end

    initial begin
        // name, r_en, wptr_gray | raddr, rptr_gray, empty, almost_empty, rd_count, underflow
        vq.push_back('{"rel_e1",  1'b0, 5'b00110, 4'd0, 5'b00000, 1'b1, 1'b1, 5'd0, 1'b0});
        vq.push_back('{"rel_e2",  1'b0, 5'b00110, 4'd0, 5'b00000, 1'b1, 1'b1, 5'd0, 1'b0});
        vq.push_back('{"rel_e3",  1'b0, 5'b00110, 4'd0, 5'b00000, 1'b0, 1'b0, 5'd4, 1'b0});
        vq.push_back('{"rd1",     1'b1, 5'b00110, 4'd1, 5'b00001, 1'b0, 1'b0, 5'd3, 1'b0});
        vq.push_back('{"rd2",     1'b1, 5'b00110, 4'd2, 5'b00011, 1'b0, 1'b1, 5'd2, 1'b0});
        vq.push_back('{"rd3",     1'b1, 5'b00110, 4'd3, 5'b00010, 1'b0, 1'b1, 5'd1, 1'b0});
        vq.push_back('{"rd_last", 1'b1, 5'b00110, 4'd4, 5'b00110, 1'b1, 1'b1, 5'd0, 1'b0});
        vq.push_back('{"uf1",     1'b1, 5'b00110, 4'd4, 5'b00110, 1'b1, 1'b1, 5'd0, 1'b1});
        vq.push_back('{"uf2",     1'b1, 5'b00110, 4'd4, 5'b00110, 1'b1, 1'b1, 5'd0, 1'b1});
        vq.push_back('{"uf3",     1'b1, 5'b00110, 4'd4, 5'b00110, 1'b1, 1'b1, 5'd0, 1'b1});
        vq.push_back('{"uf_end",  1'b0, 5'b00110, 4'd4, 5'b00110, 1'b1, 1'b1, 5'd0, 1'b0});
        vq.push_back('{"wr_e1",   1'b0, 5'b00111, 4'd4, 5'b00110, 1'b1, 1'b1, 5'd0, 1'b0});
        vq.push_back('{"wr_e2",   1'b0, 5'b00111, 4'd4, 5'b00110, 1'b1, 1'b1, 5'd0, 1'b0});
        vq.push_back('{"wr_e3",   1'b0, 5'b00111, 4'd4, 5'b00110, 1'b0, 1'b1, 5'd1, 1'b0});
        vq.push_back('{"rd_one",  1'b1, 5'b00111, 4'd5, 5'b00111, 1'b1, 1'b1, 5'd0, 1'b0});
        vq.push_back('{"w2_e1",   1'b0, 5'b00100, 4'd5, 5'b00111, 1'b1, 1'b1, 5'd0, 1'b0});
        vq.push_back('{"w2_e2",   1'b0, 5'b00100, 4'd5, 5'b00111, 1'b1, 1'b1, 5'd0, 1'b0});
        vq.push_back('{"w2_e3",   1'b0, 5'b00100, 4'd5, 5'b00111, 1'b0, 1'b1, 5'd2, 1'b0});
        vq.push_back('{"sim_rd1", 1'b1, 5'b01100, 4'd6, 5'b00101, 1'b0, 1'b1, 5'd1, 1'b0});
        vq.push_back('{"sim_rd2", 1'b1, 5'b01100, 4'd7, 5'b00100, 1'b1, 1'b1, 5'd0, 1'b0});
        vq.push_back('{"sim_uf",  1'b1, 5'b01100, 4'd7, 5'b00100, 1'b0, 1'b1, 5'd1, 1'b1});
        vq.push_back('{"sim_rd3", 1'b1, 5'b01100, 4'd8, 5'b01100, 1'b1, 1'b1, 5'd0, 1'b0});

        rrst_n    = 1'b1;
        r_en      = 1'b0;
        wptr_gray = 5'b00110;
        #1 rrst_n = 1'b0;
        #1;
        check_all("reset_async", 4'd0, 5'b00000, 1'b1, 1'b1, 5'd0, 1'b0);
        tick();
        tick();
        check_all("reset_held", 4'd0, 5'b00000, 1'b1, 1'b1, 5'd0, 1'b0);
        rrst_n = 1'b1;

        foreach (vq[i]) begin
            r_en      = vq[i].r_en;
            wptr_gray = vq[i].wg;
            tick();
            check_all(vq[i].name, vq[i].raddr, vq[i].rg, vq[i].empty, vq[i].ae, vq[i].cnt,
                      vq[i].uf);
        end

        // Full drain: write pointer jumps 16 ahead (binary 8 -> 24).
        r_en      = 1'b0;
        wptr_gray = 5'b10100;
        tick();
        tick();
        tick();
        check_all("fill16", 4'd8, 5'b01100, 1'b0, 1'b0, 5'd16, 1'b0);
        r_en = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk($sformatf("drain%0d.rd_count", k), 32'(rd_count), 32'(16 - k));
            chk($sformatf("drain%0d.raddr", k), 32'(raddr), 32'((8 + k) % 16));
            chk($sformatf("drain%0d.empty", k), 32'(empty), 32'(k == 16));
            chk($sformatf("drain%0d.almost_empty", k), 32'(almost_empty), 32'((16 - k) <= 2));
            chk($sformatf("drain%0d.underflow", k), 32'(underflow), 32'(0));
        end
        r_en = 1'b0;
        tick();
        check_all("drained", 4'd8, 5'b10100, 1'b1, 1'b1, 5'd0, 1'b0);

        // Wrap: advance read pointer to 31, then across to 0.
        wptr_gray = 5'b10000;
        tick();
        tick();
        tick();
        chk("pre_wrap.rd_count", 32'(rd_count), 32'(7));
        r_en = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk($sformatf("pre_wrap%0d.rd_count", k), 32'(rd_count), 32'(7 - k));
        end
        r_en = 1'b0;
        check_all("at31", 4'd15, 5'b10000, 1'b1, 1'b1, 5'd0, 1'b0);
        wptr_gray = 5'b00000;
        tick();
        tick();
        tick();
        check_all("wrap_avail", 4'd15, 5'b10000, 1'b0, 1'b1, 5'd1, 1'b0);
        r_en = 1'b1;
        tick();
        r_en = 1'b0;
        check_all("wrapped", 4'd0, 5'b00000, 1'b1, 1'b1, 5'd0, 1'b0);

        // Mid-operation asynchronous reset, 1 time unit wide, between edges.
        wptr_gray = 5'b01100;
        tick();
        tick();
        tick();
        check_all("mid_fill8", 4'd0, 5'b00000, 1'b0, 1'b0, 5'd8, 1'b0);
        r_en = 1'b1;
        #1 rrst_n = 1'b0;
        #1;
        check_all("mid_rst_async", 4'd0, 5'b00000, 1'b1, 1'b1, 5'd0, 1'b0);
        rrst_n = 1'b1;
        r_en   = 1'b0;
        tick();
        check_all("mid_rst_after", 4'd0, 5'b00000, 1'b1, 1'b1, 5'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
